// File: rtl/firc_pkg.sv
// -----------------------------------------------------------------------------
// firc_pkg
// Shared types and constants for the 29-tap symmetric complex FIR sequencer.
//
//   firc_state_t : LOAD (coefficient load), IDLE (waiting for a sample),
//                  MAC (15-step pre-add/MAC sweep)
//   NTAPS        : total filter taps (mirrored pairs plus a centre tap)
//   NCOEF        : unique coefficients, stored at coef-RAM addresses 1..NCOEF
//   BUF_DEPTH    : circular sample-buffer depth
//   PTR_W        : width of buffer pointers and coefficient addresses
//   LAST_STEP    : index of the centre-tap step, which is the final MAC step
//   coef_idx()   : maps a tap number to its coefficient-RAM address
// -----------------------------------------------------------------------------
package firc_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        MAC  = 2'd2
    } firc_state_t;

    localparam int NTAPS     = 29;
    localparam int NCOEF     = (NTAPS + 1) / 2;
    localparam int BUF_DEPTH = 32;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int LAST_STEP = NCOEF - 1;

    // Taps k and NTAPS-1-k share a coefficient; pair k lives at address k+1,
    // so the centre tap lands on address NCOEF.
    function automatic logic [PTR_W-1:0] coef_idx(input logic [PTR_W-1:0] tap);
        logic [PTR_W-1:0] fold;
        if (tap <= PTR_W'(LAST_STEP)) begin
            fold = tap;
        end else begin
            fold = PTR_W'(NTAPS - 1) - tap;
        end
        return fold + PTR_W'(1);
    endfunction

endpackage

// File: rtl/firc_valid_pipe.sv
// -----------------------------------------------------------------------------
// firc_valid_pipe
// DEPTH-stage valid shift register that tracks results travelling through the
// datapath MAC pipeline. A 1 presented on in_valid appears on out_valid
// exactly DEPTH cycles later. Reset empties the pipe so that results which
// were in flight are never announced.
//
// Ports
//   Clk       in  1  clock
//   Reset     in  1  synchronous, active-high clear
//   in_valid  in  1  result enters the pipe this cycle
//   out_valid out 1  result leaves the pipe this cycle
// -----------------------------------------------------------------------------
module firc_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] stage_reg;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= in_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= {stage_reg[DEPTH-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign out_valid = stage_reg[DEPTH-1];

endmodule

// File: rtl/firc_seq.sv
// -----------------------------------------------------------------------------
// firc_seq
// Control sequencer for the time-multiplexed 29-tap symmetric complex FIR.
// Owns the coefficient-load handshake, the circular sample-buffer addressing,
// input backpressure and the 15-step pre-add/MAC sweep. Sample and
// coefficient data never pass through here; the datapath acts on the strobes
// and addresses produced below.
//
// Ports
//   Clk        in   1  clock
//   Reset      in   1  synchronous, active-high reset
//   PushIn     in   1  sample offered by upstream
//   StopIn     out  1  1 = sample not accepted this cycle
//   PushCoef   in   1  coefficient write request
//   CoefAddr   in   5  coefficient address, legal 1..15
//   CoefWe     out  1  coef-RAM write strobe (same-cycle pass-through)
//   CoefErr    out  1  one-cycle pulse: illegal address or PushCoef during MAC
//   Ready      out  1  all 15 coefficients valid
//   SampWe     out  1  datapath writes the sample into buffer[SampWAddr]
//   SampWAddr  out  5  buffer write pointer
//   RdAddrA    out  5  newer operand of the pre-add pair
//   RdAddrB    out  5  older operand of the pre-add pair
//   RdBValid   out  1  0 on the centre tap (operand B forced to 0)
//   CoefRAddr  out  5  coefficient read address
//   MacClr     out  1  first MAC step (accumulator load)
//   MacEn      out  1  MAC step active
//   MacLast    out  1  final MAC step
//   PushOut    out  1  filter output valid this cycle
// -----------------------------------------------------------------------------
module firc_seq
    import firc_pkg::*;
#(
    parameter int MAC_LAT = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PushIn,
    output logic             StopIn,
    input  logic             PushCoef,
    input  logic [PTR_W-1:0] CoefAddr,
    output logic             CoefWe,
    output logic             CoefErr,
    output logic             Ready,
    output logic             SampWe,
    output logic [PTR_W-1:0] SampWAddr,
    output logic [PTR_W-1:0] RdAddrA,
    output logic [PTR_W-1:0] RdAddrB,
    output logic             RdBValid,
    output logic [PTR_W-1:0] CoefRAddr,
    output logic             MacClr,
    output logic             MacEn,
    output logic             MacLast,
    output logic             PushOut
);

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    firc_state_t      state_reg,  state_next;
    logic [3:0]       k_reg,      k_next;
    logic [PTR_W-1:0] wp_reg,     wp_next;
    logic [PTR_W-1:0] newest_reg, newest_next;
    logic [PTR_W-1:0] fill_reg,   fill_next;
    logic [NCOEF-1:0] mask_reg,   mask_next;

    // -------------------------------------------------------------------------
    // Coefficient address decode: bit gi is address gi+1.
    // -------------------------------------------------------------------------
    logic [NCOEF-1:0] coef_onehot;
    logic             coef_legal;

    generate
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef_dec
            assign coef_onehot[gi] = (CoefAddr == PTR_W'(gi + 1));
        end
    endgenerate

    assign coef_legal = |coef_onehot;

    // -------------------------------------------------------------------------
    // Sweep address generation. The step index is widened to the pointer
    // width so that all arithmetic wraps modulo the buffer depth.
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] k_ext;
    logic             k_is_last;
    logic [PTR_W-1:0] addr_a;
    logic [PTR_W-1:0] addr_b;

    assign k_ext     = PTR_W'(k_reg);
    assign k_is_last = (k_reg == 4'(LAST_STEP));
    assign addr_a    = newest_reg - k_ext;
    // The mirror partner of newest-k is newest-(NTAPS-1)+k.
    assign addr_b    = newest_reg - PTR_W'(NTAPS - 1) + k_ext;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    logic accept;
    logic coef_take;
    logic mac_last_i;

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        wp_next     = wp_reg;
        newest_next = newest_reg;
        fill_next   = fill_reg;
        mask_next   = mask_reg;

        StopIn      = 1'b1;
        CoefWe      = 1'b0;
        CoefErr     = 1'b0;
        SampWe      = 1'b0;
        RdAddrA     = '0;
        RdAddrB     = '0;
        RdBValid    = 1'b0;
        CoefRAddr   = '0;
        MacClr      = 1'b0;
        MacEn       = 1'b0;
        mac_last_i  = 1'b0;

        accept      = 1'b0;
        coef_take   = 1'b0;

        case (state_reg)
            LOAD: begin
                if (PushCoef) begin
                    if (coef_legal) begin
                        CoefWe    = 1'b1;
                        mask_next = mask_reg | coef_onehot;
                    end else begin
                        CoefErr = 1'b1;
                    end
                end
                // Leave only once the registered mask shows every coef written,
                // so Ready is visible for a cycle before samples are taken.
                if (&mask_reg) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (PushCoef) begin
                    if (coef_legal) begin
                        // A coefficient update invalidates the rest of the
                        // set; the sample history is deliberately kept.
                        coef_take  = 1'b1;
                        CoefWe     = 1'b1;
                        mask_next  = coef_onehot;
                        state_next = LOAD;
                    end else begin
                        CoefErr = 1'b1;
                    end
                end
                StopIn = coef_take;
                accept = PushIn && !coef_take;
            end

            MAC: begin
                MacEn      = 1'b1;
                MacClr     = (k_reg == 4'd0);
                mac_last_i = k_is_last;
                RdAddrA    = addr_a;
                CoefRAddr  = coef_idx(k_ext);
                if (!k_is_last) begin
                    RdAddrB  = addr_b;
                    RdBValid = 1'b1;
                end
                if (PushCoef) begin
                    CoefErr = 1'b1;
                end
                if (k_is_last) begin
                    // Opening the input on the centre step lets the next
                    // sweep start immediately: one sample per 15 cycles.
                    StopIn = 1'b0;
                    accept = PushIn;
                    if (!PushIn) begin
                        state_next = IDLE;
                    end
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end

            default: begin
                state_next = LOAD;
            end
        endcase

        if (accept) begin
            SampWe      = 1'b1;
            wp_next     = wp_reg + PTR_W'(1);
            newest_next = wp_reg;
            if (fill_reg < PTR_W'(NTAPS)) begin
                fill_next = fill_reg + PTR_W'(1);
            end
            state_next  = MAC;
            k_next      = 4'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= LOAD;
            k_reg      <= '0;
            wp_reg     <= '0;
            newest_reg <= '0;
            fill_reg   <= '0;
            mask_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            wp_reg     <= wp_next;
            newest_reg <= newest_next;
            fill_reg   <= fill_next;
            mask_reg   <= mask_next;
        end
    end

    assign SampWAddr = wp_reg;
    assign Ready     = &mask_reg;
    assign MacLast   = mac_last_i;

    // -------------------------------------------------------------------------
    // Output valid: only sweeps over a fully populated delay line produce a
    // result, announced once the datapath MAC pipeline has drained.
    // -------------------------------------------------------------------------
    logic result_valid;

    assign result_valid = mac_last_i && (fill_reg == PTR_W'(NTAPS));

    firc_valid_pipe #(
        .DEPTH (MAC_LAT)
    ) u_valid_pipe (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (result_valid),
        .out_valid (PushOut)
    );

endmodule

// File: tb/tb_firc_seq.sv
// -----------------------------------------------------------------------------
// tb_firc_seq
// Directed self-checking bench for firc_seq. Inputs change just after the
// falling edge and outputs are sampled 1 time unit later, well clear of the
// rising edge.
// -----------------------------------------------------------------------------
module tb_firc_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       PushIn;
    logic       StopIn;
    logic       PushCoef;
    logic [4:0] CoefAddr;
    logic       CoefWe;
    logic       CoefErr;
    logic       Ready;
    logic       SampWe;
    logic [4:0] SampWAddr;
    logic [4:0] RdAddrA;
    logic [4:0] RdAddrB;
    logic       RdBValid;
    logic [4:0] CoefRAddr;
    logic       MacClr;
    logic       MacEn;
    logic       MacLast;
    logic       PushOut;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    firc_seq #(.MAC_LAT(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PushIn    (PushIn),
        .StopIn    (StopIn),
        .PushCoef  (PushCoef),
        .CoefAddr  (CoefAddr),
        .CoefWe    (CoefWe),
        .CoefErr   (CoefErr),
        .Ready     (Ready),
        .SampWe    (SampWe),
        .SampWAddr (SampWAddr),
        .RdAddrA   (RdAddrA),
        .RdAddrB   (RdAddrB),
        .RdBValid  (RdBValid),
        .CoefRAddr (CoefRAddr),
        .MacClr    (MacClr),
        .MacEn     (MacEn),
        .MacLast   (MacLast),
        .PushOut   (PushOut)
    );

    // ---------------------------------------------------------------- test 1a
    task automatic test_reset();
        logic [8:0] flags;
        Reset = 1'b1; PushIn = 1'b1; PushCoef = 1'b0; CoefAddr = 5'd0;
        repeat (2) @(negedge Clk);
        #1;
        flags = {CoefWe, CoefErr, Ready, SampWe, MacEn, MacClr, MacLast, PushOut, RdBValid};
        n_checks++;
        if (StopIn !== 1'b1) begin
            n_fail++; $display("FAIL reset_stopin: got %b expected 1", StopIn);
        end
        n_checks++;
        if (flags !== 9'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000000", flags);
        end
        n_checks++;
        if ({SampWAddr, RdAddrA, RdAddrB, CoefRAddr} !== 20'h0) begin
            n_fail++; $display("FAIL reset_addrs: got %h expected 00000",
                               {SampWAddr, RdAddrA, RdAddrB, CoefRAddr});
        end
        $display("reset: StopIn=%b flags=%b", StopIn, flags);
        @(negedge Clk);
        Reset = 1'b0; PushIn = 1'b0;
    endtask

    // ---------------------------------------------------------------- test 1b
    task automatic test_coef_load();
        for (int a = 1; a <= 14; a++) begin
            @(negedge Clk);
            PushCoef = 1'b1; CoefAddr = 5'(a);
            #1;
            n_checks++;
            if ({CoefWe, CoefErr, StopIn, Ready} !== 4'b1010) begin
                n_fail++;
                $display("FAIL coef_load addr %0d: got We/Err/Stop/Ready=%b expected 1010",
                         a, {CoefWe, CoefErr, StopIn, Ready});
            end
            $display("coef_load: addr=%0d CoefWe=%b Ready=%b", a, CoefWe, Ready);
        end
        @(negedge Clk);
        PushCoef = 1'b0;
    endtask

    // ---------------------------------------------------------------- test 2
    task automatic test_coef_err();
        logic [4:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd20;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            PushCoef = 1'b1; CoefAddr = bad[i];
            #1;
            n_checks++;
            if ({CoefErr, CoefWe, StopIn} !== 3'b101) begin
                n_fail++;
                $display("FAIL coef_err addr %0d: got Err/We/Stop=%b expected 101",
                         bad[i], {CoefErr, CoefWe, StopIn});
            end
            $display("coef_err: addr=%0d CoefErr=%b CoefWe=%b", bad[i], CoefErr, CoefWe);
        end
        @(negedge Clk);
        PushCoef = 1'b0;
        #1;
        n_checks++;
        if ({CoefErr, Ready, StopIn} !== 3'b001) begin
            n_fail++;
            $display("FAIL coef_err_after: got Err/Ready/Stop=%b expected 001",
                     {CoefErr, Ready, StopIn});
        end
    endtask

    // ---------------------------------------------------------------- test 1c
    task automatic test_ready();
        @(negedge Clk);
        PushCoef = 1'b1; CoefAddr = 5'd15;
        #1;
        n_checks++;
        if ({CoefWe, Ready} !== 2'b10) begin
            n_fail++; $display("FAIL ready_last_write: got We/Ready=%b expected 10", {CoefWe, Ready});
        end
        @(negedge Clk);
        PushCoef = 1'b0;
        #1;
        n_checks++;
        if ({Ready, StopIn} !== 2'b11) begin
            n_fail++; $display("FAIL ready_rise: got Ready/Stop=%b expected 11", {Ready, StopIn});
        end
        @(negedge Clk);
        #1;
        n_checks++;
        if ({Ready, StopIn} !== 2'b10) begin
            n_fail++; $display("FAIL ready_idle: got Ready/Stop=%b expected 10", {Ready, StopIn});
        end
        $display("ready: Ready=%b StopIn=%b", Ready, StopIn);
    endtask

    // ------------------------------------------------------------ tests 3 & 4
    // 29 samples back to back. Cycle 0 accepts sample 0; sample s is accepted
    // at cycle 15*s and its sweep step k occupies cycle 15*s+1+k.
    task automatic test_stream();
        int s, k, exp_a, exp_b, exp_c;
        logic exp_we, exp_last, exp_stop, exp_out, exp_en;
        for (int cyc = 0; cyc <= 445; cyc++) begin
            @(negedge Clk);
            PushIn = (cyc <= 420);
            #1;
            exp_we   = (cyc % 15 == 0) && (cyc <= 420);
            exp_last = (cyc % 15 == 0) && (cyc >= 15) && (cyc <= 435);
            exp_stop = !((cyc % 15 == 0) || (cyc >= 436));
            exp_en   = (cyc >= 1) && (cyc <= 435);
            exp_out  = (cyc == 438);
            n_checks++;
            if ({SampWe, MacLast, StopIn, MacEn, PushOut} !==
                {exp_we, exp_last, exp_stop, exp_en, exp_out}) begin
                n_fail++;
                $display("FAIL stream cyc %0d: got We/Last/Stop/En/Out=%b expected %b", cyc,
                         {SampWe, MacLast, StopIn, MacEn, PushOut},
                         {exp_we, exp_last, exp_stop, exp_en, exp_out});
            end
            if (exp_we) begin
                n_checks++;
                if (SampWAddr !== 5'((cyc / 15) % 32)) begin
                    n_fail++;
                    $display("FAIL stream_waddr cyc %0d: got %0d expected %0d",
                             cyc, SampWAddr, (cyc / 15) % 32);
                end
                $display("stream: cyc=%0d sample=%0d SampWAddr=%0d", cyc, cyc / 15, SampWAddr);
            end
            if (exp_en) begin
                s     = (cyc - 1) / 15;
                k     = (cyc - 1) % 15;
                exp_a = (s - k + 64) % 32;
                exp_b = (s - 28 + k + 64) % 32;
                exp_c = (k < 14) ? k + 1 : 15;
                n_checks++;
                if (RdAddrA !== 5'(exp_a) || CoefRAddr !== 5'(exp_c) ||
                    RdBValid !== (k < 14) || MacClr !== (k == 0) ||
                    (k < 14 && RdAddrB !== 5'(exp_b))) begin
                    n_fail++;
                    $display("FAIL stream_sweep cyc %0d k %0d: got A=%0d B=%0d Bv=%b C=%0d Clr=%b expected A=%0d B=%0d C=%0d",
                             cyc, k, RdAddrA, RdAddrB, RdBValid, CoefRAddr, MacClr, exp_a, exp_b, exp_c);
                end
            end
            // Hand-worked vectors for newest = 5 (sample 5).
            if (cyc == 76) begin
                n_checks++;
                if ({RdAddrA, RdAddrB, CoefRAddr} !== {5'd5, 5'd9, 5'd1}) begin
                    n_fail++;
                    $display("FAIL addr_k0: got A=%0d B=%0d C=%0d expected A=5 B=9 C=1",
                             RdAddrA, RdAddrB, CoefRAddr);
                end
                $display("addr_k0: A=%0d B=%0d C=%0d", RdAddrA, RdAddrB, CoefRAddr);
            end
            if (cyc == 90) begin
                n_checks++;
                if ({RdAddrA, RdBValid, CoefRAddr} !== {5'd23, 1'b0, 5'd15}) begin
                    n_fail++;
                    $display("FAIL addr_k14: got A=%0d Bv=%b C=%0d expected A=23 Bv=0 C=15",
                             RdAddrA, RdBValid, CoefRAddr);
                end
                $display("addr_k14: A=%0d Bv=%b C=%0d", RdAddrA, RdBValid, CoefRAddr);
            end
        end
        PushIn = 1'b0;
    endtask

    // ---------------------------------------------------------------- test 5
    task automatic test_coef_during_mac();
        @(negedge Clk);
        PushIn = 1'b1;
        #1;
        n_checks++;
        if ({SampWe, SampWAddr} !== {1'b1, 5'd29}) begin
            n_fail++;
            $display("FAIL mac_coef_accept: got We=%b WAddr=%0d expected We=1 WAddr=29", SampWe, SampWAddr);
        end
        for (int j = 0; j < 15; j++) begin
            @(negedge Clk);
            PushIn = 1'b0; PushCoef = (j == 3); CoefAddr = 5'd4;
            #1;
            n_checks++;
            if ({MacEn, MacLast, CoefErr, CoefWe} !== {1'b1, (j == 14), (j == 3), 1'b0} ||
                CoefRAddr !== 5'((j < 14) ? j + 1 : 15)) begin
                n_fail++;
                $display("FAIL mac_coef step %0d: got En/Last/Err/We=%b C=%0d", j,
                         {MacEn, MacLast, CoefErr, CoefWe}, CoefRAddr);
            end
            if (j == 3) $display("mac_coef: step=3 CoefErr=%b CoefWe=%b", CoefErr, CoefWe);
        end
        PushCoef = 1'b0;
        for (int o = 1; o <= 3; o++) begin
            @(negedge Clk);
            #1;
            n_checks++;
            if (PushOut !== (o == 3)) begin
                n_fail++;
                $display("FAIL mac_coef_pushout +%0d: got %b expected %b", o, PushOut, (o == 3));
            end
        end
        $display("mac_coef: PushOut=%b three cycles after MacLast", PushOut);
        // Coefficient and sample offered together in IDLE: the coefficient wins.
        @(negedge Clk);
        PushIn = 1'b1; PushCoef = 1'b1; CoefAddr = 5'd3;
        #1;
        n_checks++;
        if ({CoefWe, StopIn, SampWe, CoefErr} !== 4'b1100) begin
            n_fail++;
            $display("FAIL idle_collide: got We/Stop/SampWe/Err=%b expected 1100",
                     {CoefWe, StopIn, SampWe, CoefErr});
        end
        @(negedge Clk);
        PushIn = 1'b0; PushCoef = 1'b0;
        #1;
        n_checks++;
        if ({StopIn, Ready, MacEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_collide_load: got Stop/Ready/En=%b expected 100", {StopIn, Ready, MacEn});
        end
        $display("idle_collide: StopIn=%b Ready=%b", StopIn, Ready);
    endtask

    // ---------------------------------------------------------------- test 6
    task automatic test_reset_mid_sweep();
        logic got_idle;
        logic saw_out;
        for (int a = 1; a <= 15; a++) begin
            if (a != 3) begin
                @(negedge Clk);
                PushCoef = 1'b1; CoefAddr = 5'(a);
            end
        end
        @(negedge Clk);
        PushCoef = 1'b0;
        got_idle = 1'b0;
        for (int i = 0; i < 5 && !got_idle; i++) begin
            @(negedge Clk);
            #1;
            if (StopIn === 1'b0) got_idle = 1'b1;
        end
        n_checks++;
        if (got_idle !== 1'b1) begin
            n_fail++; $display("FAIL reload_idle: got StopIn=%b expected 0 within 5 cycles", StopIn);
        end
        @(negedge Clk);
        PushIn = 1'b1;
        repeat (7) begin
            @(negedge Clk);
            PushIn = 1'b0;
        end
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({MacEn, CoefRAddr} !== {1'b1, 5'd8}) begin
            n_fail++;
            $display("FAIL rst_mid_k7: got En=%b C=%0d expected En=1 C=8", MacEn, CoefRAddr);
        end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({StopIn, MacEn, Ready, MacLast} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid_after: got Stop/En/Ready/Last=%b expected 1000",
                     {StopIn, MacEn, Ready, MacLast});
        end
        saw_out = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            #1;
            if (PushOut === 1'b1 || MacEn === 1'b1) saw_out = 1'b1;
        end
        n_checks++;
        if (saw_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got activity=%b expected 0", saw_out);
        end
        $display("rst_mid: StopIn=%b MacEn=%b activity=%b", StopIn, MacEn, saw_out);
    endtask

    initial begin
        test_reset();
        test_coef_load();
        test_coef_err();
        test_ready();
        test_stream();
        test_coef_during_mac();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
